// File: rtl/pixel_packer_if.sv
// pixel_packer_if: pixel stream in, image-memory write bus out.
interface pixel_packer_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic              pix_last;
    logic              pix_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    modport master (output pix_data, pix_valid, pix_last, input pix_ready, mem_we, mem_addr, mem_wdata);
    modport slave  (input pix_data, pix_valid, pix_last, output pix_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/pixel_packer.sv
// pixel_packer: packs 8-bit pixel pairs into 16-bit image-memory words, one frame per start.
// Define PIXEL_PACKER_CLEAR_EN to zero the frame region before accepting pixels.
module pixel_packer #(
    parameter int FRAME_WORDS = 16384,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [14:0]       words_written,
    pixel_packer_if.slave     bus
);
    localparam logic [14:0] FW = 15'(FRAME_WORDS);
    typedef enum logic [2:0] {IDLE, CLEAR, LOW, HIGH, FLUSH, DONE} state_t;
`ifdef PIXEL_PACKER_CLEAR_EN
    localparam state_t FIRST = CLEAR;
    logic [14:0] cc, cc_n;
`else
    localparam state_t FIRST = LOW;
`endif
    state_t state, state_n;
    logic [ADDR_W-1:0] base, base_n, addr_n;
    logic [7:0] lo, lo_n;
    logic [14:0] wc, wc_n;
    logic [15:0] wdata_n;
    logic we_n, go, acc;
    assign go = start && state == IDLE && !busy;
    assign acc = bus.pix_valid && bus.pix_ready;
    assign bus.pix_ready = state == LOW || state == HIGH;
    assign words_written = wc;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = go ? FIRST : IDLE;
`ifdef PIXEL_PACKER_CLEAR_EN
            CLEAR: state_n = cc == FW ? LOW : CLEAR;
`endif
            LOW:   if (acc) state_n = bus.pix_last ? FLUSH : HIGH;
            HIGH:  if (acc) state_n = (bus.pix_last || wc + 15'd1 == FW) ? DONE : LOW;
            FLUSH: state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // next values of the registered write bus and datapath
    always_comb begin
        we_n = 1'b0;
        addr_n = bus.mem_addr;
        wdata_n = bus.mem_wdata;
        lo_n = lo;
        wc_n = wc;
        base_n = base;
`ifdef PIXEL_PACKER_CLEAR_EN
        cc_n = cc;
`endif
        case (state)
            IDLE: if (go) begin
                base_n = base_addr;
                wc_n = '0;
`ifdef PIXEL_PACKER_CLEAR_EN
                we_n = 1'b1;
                addr_n = base_addr;
                wdata_n = '0;
                cc_n = 15'd1;
`endif
            end
`ifdef PIXEL_PACKER_CLEAR_EN
            CLEAR: if (cc != FW) begin
                we_n = 1'b1;
                addr_n = base + cc[ADDR_W-1:0];
                wdata_n = '0;
                cc_n = cc + 15'd1;
            end
`endif
            LOW: if (acc) lo_n = bus.pix_data;
            HIGH: if (acc) begin
                we_n = 1'b1;
                addr_n = base + wc[ADDR_W-1:0];
                wdata_n = {bus.pix_data, lo};
                wc_n = wc + 15'd1;
            end
            FLUSH: begin
                we_n = 1'b1;
                addr_n = base + wc[ADDR_W-1:0];
                wdata_n = {8'h00, lo};
                wc_n = wc + 15'd1;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.mem_we <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_wdata <= '0;
            base <= '0;
            lo <= '0;
            wc <= '0;
            busy <= 1'b0;
            done <= 1'b0;
`ifdef PIXEL_PACKER_CLEAR_EN
            cc <= '0;
`endif
        end else begin
            bus.mem_we <= we_n;
            bus.mem_addr <= addr_n;
            bus.mem_wdata <= wdata_n;
            base <= base_n;
            lo <= lo_n;
            wc <= wc_n;
            busy <= state_n != IDLE || state == DONE;
            done <= state == DONE;
`ifdef PIXEL_PACKER_CLEAR_EN
            cc <= cc_n;
`endif
        end
endmodule
